// File: rtl/serial_adder_pkg.sv
// Shared definitions for the multi-cycle arithmetic blocks: FSM state
// encodings and a helper for sizing step counters.
package serial_adder_pkg;

   // FSM state encodings shared with sibling multi-cycle arithmetic blocks
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Width of a counter that must hold 0..n-1; never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      if (n > 1) begin
         w = $clog2(n);
      end
      return w;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Bit-level adder cells: half_adder and the full_adder built from two of them.

module half_adder (
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b;
   assign carry = a & b;

endmodule

module full_adder (
   input  logic A,
   input  logic B,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a     (A),
      .b     (B),
      .sum   (s0),
      .carry (c0)
   );

   half_adder u_ha1 (
      .a     (s0),
      .b     (cin),
      .sum   (sum),
      .carry (c1)
   );

   assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits per
// clock, through a DIGIT-wide ripple slice of full adders. start/busy/done
// handshake; results are registered and held until the next completion.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned CNT_W = cnt_width(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   // Ripple slice carry chain: c[i] is the carry into slice bit i
   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] s;
   logic [WIDTH-1:0] res_nxt;

   assign c[0] = carry_q;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_slice
         full_adder u_fa (
            .A    (a_q[i]),
            .B    (b_q[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
         );
      end

      // Slice result enters from the MSB side so the final step leaves the
      // first digit in the LSBs; a single-step add takes the slice as-is.
      if (DIGIT == WIDTH) begin : g_res_full
         assign res_nxt = s;
      end else begin : g_res_shift
         assign res_nxt = {s, res_q[WIDTH-1:DIGIT]};
      end
   endgenerate

   // Sequencer and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  res_q   <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               carry_q <= c[DIGIT];
               res_q   <= res_nxt;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_q  <= res_nxt;
                  cout_q <= c[DIGIT];
                  ovf_q  <= c[DIGIT-1] ^ c[DIGIT];
                  state  <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a W8/D1 instance checked every cycle against a
// timeline model, plus W8/D4, W8/D8 and W4/D2 instances run in lockstep.
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   // W8/D1 instance
   logic       m_start = 1'b0, m_cin = 1'b0;
   logic [7:0] m_a = '0, m_b = '0;
   logic       m_busy, m_done, m_cout, m_ovf;
   logic [7:0] m_sum;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_main (
      .clk(clk), .rst_n(rst_n), .start(m_start), .A(m_a), .B(m_b), .cin(m_cin),
      .busy(m_busy), .done(m_done), .sum(m_sum), .cout(m_cout), .ovf(m_ovf)
   );

   // Lockstep instances sharing stimulus
   logic       x_start = 1'b0, x_cin = 1'b0;
   logic [7:0] x_a = '0, x_b = '0;
   logic       busy4, done4, cout4, ovf4;
   logic [7:0] sum4;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;
   logic       busy2, done2, cout2, ovf2;
   logic [3:0] sum2;

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(x_start), .A(x_a), .B(x_b), .cin(x_cin),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
   );
   serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(x_start), .A(x_a), .B(x_b), .cin(x_cin),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );
   serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(x_start), .A(x_a[3:0]), .B(x_b[3:0]), .cin(x_cin),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: returns {ovf, cout, sum[7:0]} of a w-bit add a+b+c
   function automatic logic [9:0] ref_add(input int w, input int a, input int b, input int c);
      int u, sa, sb, s;
      logic [9:0] r;
      u  = a + b + c;
      sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
      sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
      s  = sa + sb + c;
      r = '0;
      r[7:0] = 8'(u % (1 << w));
      r[8]   = ((u >> w) & 1) != 0;
      r[9]   = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
      return r;
   endfunction

   // Timeline model of the W8/D1 instance: t=0 idle, t=1..8 busy, t=9 done
   int         t = 0;
   logic [9:0] m_pend = '0;
   logic [9:0] m_exp = '0;
   bit         chk_on = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t = 0;
         m_exp = '0;
      end else if (t == 0) begin
         if (m_start) begin
            t = 1;
            m_pend = ref_add(8, int'(m_a), int'(m_b), int'(m_cin));
         end
      end else if (t <= 8) begin
         t++;
         if (t == 9) m_exp = m_pend;
      end else begin
         t = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("cyc_busy", 32'(m_busy), 32'(t >= 1 && t <= 8));
         check("cyc_done", 32'(m_done), 32'(t == 9));
         check("cyc_result", 32'({m_ovf, m_cout, m_sum}), 32'(m_exp));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (t != 0 && g < 20) begin
         tick();
         g++;
      end
      check("idle_wait", 32'(t), 32'd0);
   endtask

   task automatic run_main(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [9:0] exp, input bit poke, input string nm);
      int e, nb, nd;
      wait_idle();
      m_a = a; m_b = b; m_cin = c; m_start = 1'b1;
      tick();
      e = 1; nb = 0;
      m_start = 1'b0;
      m_a = 8'($urandom); m_b = 8'($urandom); m_cin = 1'($urandom);
      if (m_busy) nb++;
      while (!m_done && e < 20) begin
         m_start = poke && (e == 3);
         tick();
         e++;
         if (m_busy) nb++;
      end
      m_start = 1'b0;
      check({nm, "_latency"}, 32'(e), 32'd9);
      check({nm, "_busy_cycles"}, 32'(nb), 32'd8);
      check({nm, "_result"}, 32'({m_ovf, m_cout, m_sum}), 32'(exp));
      if (poke) begin
         m_start = 1'b1;
         m_a = 8'h55;
      end
      tick();
      m_start = 1'b0;
      nd = 0;
      repeat (4) begin
         tick();
         if (m_done) nd++;
      end
      check({nm, "_extra_done"}, 32'(nd), 32'd0);
      check({nm, "_held"}, 32'({m_ovf, m_cout, m_sum}), 32'(exp));
   endtask

   task automatic run3(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output logic [9:0] r4o);
      int e, l4, l8, l2;
      logic [9:0] r4, r8, r2;
      l4 = 0; l8 = 0; l2 = 0; r4 = '0; r8 = '0; r2 = '0;
      x_a = a; x_b = b; x_cin = c; x_start = 1'b1;
      tick();
      x_start = 1'b0;
      x_a = 8'($urandom); x_b = 8'($urandom); x_cin = 1'($urandom);
      e = 1;
      repeat (6) begin
         if (done4 && l4 == 0) begin l4 = e; r4 = {ovf4, cout4, sum4}; end
         if (done8 && l8 == 0) begin l8 = e; r8 = {ovf8, cout8, sum8}; end
         if (done2 && l2 == 0) begin l2 = e; r2 = {ovf2, cout2, 4'h0, sum2}; end
         tick();
         e++;
      end
      check("d4_latency", 32'(l4), 32'd3);
      check("d8_latency", 32'(l8), 32'd2);
      check("w4d2_latency", 32'(l2), 32'd3);
      check("d4_result", 32'(r4), 32'(ref_add(8, int'(a), int'(b), int'(c))));
      check("d8_result", 32'(r8), 32'(ref_add(8, int'(a), int'(b), int'(c))));
      check("w4d2_result", 32'(r2),
            32'(ref_add(4, int'(a[3:0]), int'(b[3:0]), int'(c))));
      r4o = r4;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] r;
      int nd;
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy", 32'(m_busy), 32'd0);
      check("rst_done", 32'(m_done), 32'd0);
      check("rst_result", 32'({m_ovf, m_cout, m_sum}), 32'd0);
      check("rst_trio_busy", 32'({busy4, busy8, busy2}), 32'd0);
      check("rst_trio_out", 32'({cout4, ovf4, sum4, cout2, ovf2, sum2}), 32'd0);
      rst_n = 1'b1;
      chk_on = 1'b1;
      tick();

      run_main(8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00}, 1'b0, "zero");
      run_main(8'hFF, 8'h01, 1'b0, {1'b0, 1'b1, 8'h00}, 1'b0, "carry");
      run_main(8'h7F, 8'h01, 1'b0, {1'b1, 1'b0, 8'h80}, 1'b0, "ovf");
      run_main(8'hFF, 8'hFF, 1'b1, {1'b0, 1'b1, 8'hFF}, 1'b0, "allones");
      run_main(8'h40, 8'h45, 1'b0, {1'b1, 1'b0, 8'h85}, 1'b1, "ignored_start");

      // Reset in the middle of a run: no done, everything cleared
      wait_idle();
      m_a = 8'h12; m_b = 8'h34; m_cin = 1'b0; m_start = 1'b1;
      tick();
      m_start = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(m_busy), 32'd0);
      check("midrst_done", 32'(m_done), 32'd0);
      check("midrst_result", 32'({m_ovf, m_cout, m_sum}), 32'd0);
      tick();
      rst_n = 1'b1;
      nd = 0;
      repeat (12) begin
         tick();
         if (m_done) nd++;
      end
      check("midrst_no_done", 32'(nd), 32'd0);

      // Randomized traffic, including starts during RUN and DONE
      repeat (400) begin
         m_start = ($urandom % 3) == 0;
         m_a = 8'($urandom); m_b = 8'($urandom); m_cin = 1'($urandom);
         tick();
      end
      m_start = 1'b0;
      repeat (12) tick();

      // Wider digits and single-step add
      run3(8'h3C, 8'hC4, 1'b0, r);
      check("d4_3C_C4", 32'(r), 32'({1'b0, 1'b1, 8'h00}));

      // Exhaustive W4/D2, random upper nibbles for the 8-bit instances
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               run3({4'($urandom), 4'(a)}, {4'($urandom), 4'(b)}, 1'(c), r);
            end
         end
      end

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
